// File: rtl/adaptiv_array_drain_pkg.sv
// Shared types and helpers for the adaptiv_array drain path and its benches.
// Holds the FSM encoding, the index-width calculation and flattened (r,c) word addressing.
package adaptiv_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    function automatic int idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // LSB position of word (r,c) in a row-major flattened bus
    function automatic int word_lsb(input int r, input int c, input int cols, input int wsize);
        return (r * cols + c) * wsize;
    endfunction

endpackage

// File: rtl/adaptiv_array_drain_next_row.sv
// Priority search: lowest row >= i_start whose mask bit is set; the final row is always eligible.
// Purely combinational; with an all-ones mask it reduces to o_row = i_start.
module adaptiv_drain_next_row
    import adaptiv_pkg::*;
#(
    parameter int ROWS = 64,
    parameter int IDXW = idx_width(ROWS)
) (
    input  logic [ROWS-1:0] i_mask,
    input  logic [IDXW-1:0] i_start,
    output logic [IDXW-1:0] o_row
);

    always_comb begin
        o_row = IDXW'(ROWS - 1);
        for (int r = ROWS - 2; r >= 0; r--) begin
            if (i_mask[r] && (r >= int'(i_start))) begin
                o_row = IDXW'(r);
            end
        end
    end

endmodule

// File: rtl/adaptiv_array_drain.sv
// Snapshots the systolic array result bus and streams it out one row per beat (valid/ready).
// Optional ADAPTIV_DRAIN_ZERO_SKIP_EN skips all-zero rows (the final row is always emitted).
module adaptiv_array_drain
    import adaptiv_pkg::*;
#(
    parameter int ROWS      = 64,
    parameter int COLS      = 16,
    parameter int WORD_SIZE = 16,
    localparam int IDXW     = idx_width(ROWS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] array_out_bus,
    input  logic                           capture_valid,
    output logic                           capture_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [COLS*WORD_SIZE-1:0]      out_data,
    output logic [IDXW-1:0]                out_row_idx,
    output logic                           out_last,
    output logic                           overrun
);

    localparam int ROWW = COLS * WORD_SIZE;
    localparam logic [IDXW-1:0] LAST_ROW = IDXW'(ROWS - 1);

    drain_state_e             r_state;
    logic [IDXW-1:0]          r_row_ptr;
    logic [ROWS*ROWW-1:0]     r_snap;
    logic                     r_overrun;

    logic                     w_last;
    logic                     w_cap;
    logic                     w_hs;
    logic [IDXW-1:0]          w_ptr_inc;
    logic [IDXW-1:0]          w_first_row;
    logic [IDXW-1:0]          w_next_row;
    logic [ROWS-1:0]          w_emit_mask;
    logic [ROWW-1:0]          w_row;

    assign w_last        = (r_state == ST_DRAIN) && (r_row_ptr == LAST_ROW);
    assign capture_ready = (r_state == ST_IDLE) || (w_last && out_ready);
    assign w_cap         = capture_valid && capture_ready;
    assign w_hs          = out_valid && out_ready;
    assign w_ptr_inc     = r_row_ptr + 1'b1;

    assign w_row       = r_snap[word_lsb(int'(r_row_ptr), 0, COLS, WORD_SIZE) +: ROWW];
    assign out_valid   = (r_state == ST_DRAIN);
    assign out_last    = w_last;
    assign out_row_idx = r_row_ptr;
    assign out_data    = out_valid ? w_row : '0;
    assign overrun     = r_overrun;

`ifdef ADAPTIV_DRAIN_ZERO_SKIP_EN
    logic [ROWS-1:0] w_live_mask;
    logic [ROWS-1:0] r_mask;

    always_comb begin
        w_live_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_live_mask[r] = |array_out_bus[word_lsb(r, 0, COLS, WORD_SIZE) +: ROWW];
        end
    end

    assign w_emit_mask = r_mask;

    adaptiv_drain_next_row #(
        .ROWS (ROWS),
        .IDXW (IDXW)
    ) u_first_row (
        .i_mask  (w_live_mask),
        .i_start ('0),
        .o_row   (w_first_row)
    );
`else
    // Every row is emitted, so the search collapses to a plain increment
    assign w_emit_mask = '1;
    assign w_first_row = '0;
`endif

    adaptiv_drain_next_row #(
        .ROWS (ROWS),
        .IDXW (IDXW)
    ) u_next_row (
        .i_mask  (w_emit_mask),
        .i_start (w_ptr_inc),
        .o_row   (w_next_row)
    );

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_snap <= array_out_bus;
`ifdef ADAPTIV_DRAIN_ZERO_SKIP_EN
            r_mask <= w_live_mask;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_row_ptr <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (capture_valid && !capture_ready) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cap) begin
                        r_row_ptr <= w_first_row;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A capture accepted here coincides with the last-beat handshake
                    if (w_cap) begin
                        r_row_ptr <= w_first_row;
                    end else if (w_hs) begin
                        if (w_last) begin
                            r_state   <= ST_IDLE;
                            r_row_ptr <= '0;
                        end else begin
                            r_row_ptr <= w_next_row;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_row_ptr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adaptiv_array_drain.sv
// Scoreboard bench for adaptiv_array_drain: expected beats are queued at capture and checked on handshake.
module tb_adaptiv_array_drain;

    localparam int ROWS = 64;
    localparam int COLS = 16;
    localparam int W    = 16;
    localparam int IDXW = $clog2(ROWS);
    localparam int ROWW = COLS * W;
    localparam int BUSW = ROWS * ROWW;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            last;
        logic [ROWW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [BUSW-1:0]   array_out_bus;
    logic              capture_valid;
    logic              capture_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ROWW-1:0]   out_data;
    logic [IDXW-1:0]   out_row_idx;
    logic              out_last;
    logic              overrun;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    adaptiv_array_drain #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .WORD_SIZE (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .array_out_bus (array_out_bus),
        .capture_valid (capture_valid),
        .capture_ready (capture_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row_idx   (out_row_idx),
        .out_last      (out_last),
        .overrun       (overrun)
    );

    function automatic logic [BUSW-1:0] make_bus(input int base);
        logic [BUSW-1:0] b;
        b = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[(r*COLS + c)*W +: W] = W'(base + r*COLS + c);
        return b;
    endfunction

    // Reference model: which rows a snapshot must produce, in order
    function automatic void push_snapshot(input logic [BUSW-1:0] b);
        beat_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.idx  = IDXW'(r);
            e.last = (r == ROWS - 1);
            e.data = b[r*ROWW +: ROWW];
`ifdef ADAPTIV_DRAIN_ZERO_SKIP_EN
            if (e.data == '0 && r != ROWS - 1) continue;
`endif
            exp_q.push_back(e);
        end
    endfunction

    // Called at a negedge with capture_ready expected high
    task automatic do_capture(input logic [BUSW-1:0] b);
        array_out_bus = b;
        capture_valid = 1'b1;
        push_snapshot(b);
        @(posedge clk);
        #1;
        capture_valid = 1'b0;
    endtask

    // Consumes beats with out_ready high pct% of cycles; returns at the negedge where beats==stop_beat
    task automatic consume(input int pct, input int stop_beat, output int beats);
        beat_t obs, held, e;
        bit    stalled;
        int    cyc;
        stalled = 1'b0;
        cyc     = 0;
        beats   = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 2000) begin
                n_checks++;
                $display("FAIL consume_timeout: beats=%0d still pending=%0d", beats, exp_q.size());
                return;
            end
            if (stop_beat >= 0 && beats == stop_beat) return;
            if (!out_valid) continue;
            obs = {out_row_idx, out_last, out_data};
            if (stalled) begin
                n_checks++;
                if (obs !== held)
                    $display("FAIL stall_hold: idx=%0d last=%0d held idx=%0d last=%0d", obs.idx, obs.last, held.idx, held.last);
                else
                    n_pass++;
            end
            out_ready = ($urandom_range(0, 99) < pct);
            #1;
            if (!out_ready) begin
                stalled = 1'b1;
                held    = obs;
                continue;
            end
            stalled = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got idx=%0d, no beat expected", obs.idx);
                return;
            end
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL beat: idx=%0d last=%0d data=%h expected idx=%0d last=%0d data=%h",
                         obs.idx, obs.last, obs.data[63:0], e.idx, e.last, e.data[63:0]);
            else
                n_pass++;
            n_checks++;
            if (capture_ready !== e.last)
                $display("FAIL capture_ready_beat: idx=%0d got=%0b expected=%0b", obs.idx, capture_ready, e.last);
            else
                n_pass++;
            beats++;
            if (e.last) begin
                @(posedge clk);
                #1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({out_valid, out_last, overrun, capture_ready} !== 4'b0001 || out_data !== '0 || out_row_idx !== '0)
            $display("FAIL reset_state: valid=%0b last=%0b overrun=%0b cap_rdy=%0b idx=%0d expected 0 0 0 1 0",
                     out_valid, out_last, overrun, capture_ready, out_row_idx);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        int beats;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL idle_valid: got=%0b expected=0", out_valid);
        else n_pass++;
        out_ready = 1'b1;
        do_capture(make_bus(0));
        n_checks++;
        if (out_valid !== 1'b1 || out_row_idx !== '0)
            $display("FAIL first_beat_latency: valid=%0b idx=%0d expected valid=1 idx=0", out_valid, out_row_idx);
        else
            n_pass++;
        consume(100, -1, beats);
        n_checks++;
        if (beats !== ROWS) $display("FAIL stream_count: got=%0d expected=%0d", beats, ROWS);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int beats;
        @(negedge clk);
        do_capture(make_bus(500));
        consume(50, -1, beats);
        n_checks++;
        if (beats !== ROWS || exp_q.size() != 0)
            $display("FAIL bp_count: got=%0d left=%0d expected=%0d left=0", beats, exp_q.size(), ROWS);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int    beats;
        beat_t obs, e;
        @(negedge clk);
        out_ready = 1'b1;
        do_capture(make_bus(2000));
        consume(100, ROWS - 1, beats);
        out_ready     = 1'b1;
        array_out_bus = make_bus(1000);
        capture_valid = 1'b1;
        #1;
        obs = {out_row_idx, out_last, out_data};
        e   = exp_q.pop_front();
        n_checks++;
        if (obs !== e || capture_ready !== 1'b1)
            $display("FAIL b2b_last_beat: idx=%0d last=%0d cap_rdy=%0b expected idx=%0d last=%0d cap_rdy=1",
                     obs.idx, obs.last, capture_ready, e.idx, e.last);
        else
            n_pass++;
        push_snapshot(make_bus(1000));
        @(posedge clk);
        #1;
        capture_valid = 1'b0;
        out_ready     = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_row_idx !== '0 || out_data[W-1:0] !== W'(1000))
            $display("FAIL b2b_no_bubble: valid=%0b idx=%0d word0=%0d expected valid=1 idx=0 word0=1000",
                     out_valid, out_row_idx, out_data[W-1:0]);
        else
            n_pass++;
        consume(100, -1, beats);
        n_checks++;
        if (beats !== ROWS) $display("FAIL b2b_count: got=%0d expected=%0d", beats, ROWS);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int beats;
        @(negedge clk);
        out_ready = 1'b1;
        do_capture(make_bus(3000));
        consume(100, 10, beats);
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL overrun_pre: got=%0b expected=0", overrun);
        else n_pass++;
        array_out_bus = make_bus(7000);
        capture_valid = 1'b1;
        out_ready     = 1'b0;
        #1;
        n_checks++;
        if (capture_ready !== 1'b0) $display("FAIL overrun_cap_rdy: got=%0b expected=0", capture_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        capture_valid = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got=%0b expected=1", overrun);
        else n_pass++;
        consume(100, -1, beats);
        n_checks++;
        if (beats !== ROWS - 10) $display("FAIL overrun_rest: got=%0d expected=%0d", beats, ROWS - 10);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got=%0b expected=1", overrun);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int beats;
        @(negedge clk);
        out_ready = 1'b1;
        do_capture(make_bus(4000));
        consume(100, 30, beats);
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, overrun, capture_ready} !== 4'b0001 || out_data !== '0 || out_row_idx !== '0)
            $display("FAIL async_reset: valid=%0b last=%0b overrun=%0b cap_rdy=%0b idx=%0d expected 0 0 0 1 0",
                     out_valid, out_last, overrun, capture_ready, out_row_idx);
        else
            n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (capture_ready !== 1'b1 || overrun !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL post_reset: cap_rdy=%0b overrun=%0b valid=%0b expected 1 0 0", capture_ready, overrun, out_valid);
        else
            n_pass++;
    endtask

    task automatic test_zero_rows();
        int              beats;
        int              exp_sparse;
        int              exp_empty;
        logic [BUSW-1:0] b;
        logic [BUSW-1:0] full;
`ifdef ADAPTIV_DRAIN_ZERO_SKIP_EN
        exp_sparse = 3;
        exp_empty  = 1;
`else
        exp_sparse = ROWS;
        exp_empty  = ROWS;
`endif
        full = make_bus(100);
        b    = '0;
        b[3*ROWW  +: ROWW] = full[3*ROWW  +: ROWW];
        b[40*ROWW +: ROWW] = full[40*ROWW +: ROWW];
        @(negedge clk);
        out_ready = 1'b1;
        do_capture(b);
        consume(100, -1, beats);
        n_checks++;
        if (beats !== exp_sparse) $display("FAIL sparse_count: got=%0d expected=%0d", beats, exp_sparse);
        else n_pass++;
        @(negedge clk);
        do_capture('0);
        consume(100, -1, beats);
        n_checks++;
        if (beats !== exp_empty) $display("FAIL empty_count: got=%0d expected=%0d", beats, exp_empty);
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b0;
        array_out_bus = '0;
        capture_valid = 1'b0;
        out_ready     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_async_reset();
        test_zero_rows();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
